uart_result_tx: RTL and testbench



---
 rtl/uart_result_tx.sv | 135 +++++++++++++
 tb/tb_uart_result_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_tx.sv
// uart_result_tx: serializes a NUM_BYTES-byte result word onto an 8N1 UART line,
// most-significant byte first, back-to-back frames, LSB first within a byte.
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   send request, sampled every cycle while idle
//   data_in     in   word to send, latched on acceptance
//   busy        out  high from the cycle after acceptance until the last stop bit ends
//   done        out  one-cycle pulse when the last stop bit has finished
//   tx          out  registered serial line, idle high
module uart_result_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int NUM_BYTES = 8
) (
    input  logic                   clk_100MHz,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   tx
);

    localparam int DATA_W = 8 * NUM_BYTES;
    localparam int DIV    = CLK_FREQ / BAUD;
    localparam int TW     = $clog2(DIV);
    localparam int BYW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t            r_state;
    logic [TW-1:0]     r_tick;
    logic [2:0]        r_bit;
    logic [BYW-1:0]    r_byte;
    logic [DATA_W-1:0] r_sreg;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;

    logic [7:0]        w_byte;
    logic              w_bit_end;

    // The byte on the wire is always the top byte; later bytes shift up into it.
    assign w_byte    = r_sreg[DATA_W-1 -: 8];
    assign w_bit_end = (r_tick == TW'(DIV - 1));

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    // tx is loaded one cycle ahead of each bit boundary so the line is a clean
    // register output and never sees start/data_in combinationally.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_sreg  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_sreg  <= data_in;
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_byte  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_byte[0];
                        r_state <= DATA_BITS;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                DATA_BITS: begin
                    if (w_bit_end) begin
                        r_tick <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP_BIT;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= w_byte[r_bit + 3'd1];
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                STOP_BIT: begin
                    if (w_bit_end) begin
                        r_tick <= '0;
                        if (r_byte == BYW'(NUM_BYTES - 1)) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_sreg  <= r_sreg << 8;
                            r_byte  <= r_byte + BYW'(1);
                            r_tx    <= 1'b0;
                            r_state <= START_BIT;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: directed bench for uart_result_tx with DIV=4,
// plus a default-parameter instance for bit-period measurement.
module tb_uart_result_tx;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [63:0] data_in;
    logic        busy;
    logic        done;
    logic        tx;

    logic        rst2_n;
    logic        start2;
    logic [63:0] data2;
    logic        busy2;
    logic        done2;
    logic        tx2;

    int n_chk  = 0;
    int n_pass = 0;

    uart_result_tx #(
        .CLK_FREQ (100),
        .BAUD     (25),
        .NUM_BYTES(8)
    ) dut (
        .clk_100MHz(clk),
        .reset_n   (reset_n),
        .start     (start),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .tx        (tx)
    );

    uart_result_tx dut_def (
        .clk_100MHz(clk),
        .reset_n   (rst2_n),
        .start     (start2),
        .data_in   (data2),
        .busy      (busy2),
        .done      (done2),
        .tx        (tx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drives start for one edge (the acceptance edge E), returns #1 after E.
    task automatic accept(input logic [63:0] d);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = {$urandom, $urandom};
    endtask

    // Entered #1 after E; returns #1 after edge E+320 (the done cycle).
    task automatic watch_word(input logic [63:0] d, input bit inject,
                              input string tag);
        int werr = 0;
        int ferr = 0;
        int bcnt = 0;
        int dcnt = 0;
        int f;
        int p;
        logic [7:0] cb;
        logic       e;
        logic [7:0] rx [8];
        for (int i = 0; i < 8; i++) rx[i] = 8'h00;
        for (int k = 0; k < 320; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (inject && k == 100) begin
                start   = 1'b0;
                data_in = 64'h0;
            end
            f  = k / 40;
            p  = (k % 40) / 4;
            cb = d[63 - 8*f -: 8];
            if (p == 0) e = 1'b0;
            else if (p == 9) e = 1'b1;
            else e = cb[p-1];
            if (tx !== e) werr++;
            if (busy === 1'b1) bcnt++;
            if (done !== 1'b0) dcnt++;
            if (k % 4 == 2) begin
                if (p == 0 && tx !== 1'b0) ferr++;
                else if (p == 9 && tx !== 1'b1) ferr++;
                else if (p >= 1 && p <= 8) rx[f][p-1] = tx;
            end
            if (inject && k == 99) begin
                start   = 1'b1;
                data_in = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_wave"}, werr, 0);
        check({tag, "_frame"}, ferr, 0);
        check({tag, "_busy_len"}, bcnt, 320);
        check({tag, "_early_done"}, dcnt, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
        for (int i = 0; i < 8; i++)
            check({tag, "_byte"}, rx[i], d[63 - 8*i -: 8]);
    endtask

    initial begin
        int cnt;
        logic [63:0] d1;
        logic [63:0] d3;
        d1 = 64'h0123_4567_89AB_CDEF;
        d3 = 64'hA5A5_A5A5_5A5A_5A5A;

        reset_n = 1'b0;
        start   = 1'b0;
        data_in = 64'h0;
        rst2_n  = 1'b0;
        start2  = 1'b0;
        data2   = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        rst2_n  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        check("idle_line", cnt, 0);

        accept(d1);
        check("accept_tx", tx, 0);
        check("accept_busy", busy, 1);
        watch_word(d1, 1'b0, "single");
        @(posedge clk);
        #1;
        check("single_done_pulse", done, 0);

        accept(d1);
        watch_word(d1, 1'b1, "busy_start");
        @(posedge clk);
        #1;
        check("busy_start_done_pulse", done, 0);

        accept(d1);
        watch_word(d1, 1'b0, "b2b_first");
        accept(d3);
        watch_word(d3, 1'b0, "b2b_second");
        @(posedge clk);
        #1;

        accept(d1);
        repeat (57) @(posedge clk);
        #1;
        check("pre_rst_tx", tx, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) cnt++;
        end
        check("midrst_quiet", cnt, 0);
        accept(d3);
        watch_word(d3, 1'b0, "after_rst");

        start2 = 1'b1;
        data2  = d1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20000 && tx2 === 1'b0; i++) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("def_start_bit", cnt, 10416);
        cnt = 0;
        for (int i = 0; i < 20000 && tx2 === 1'b1; i++) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        check("def_data_bit", cnt, 10416);
        check("def_busy", busy2, 1);
        rst2_n = 1'b0;
        #1;
        check("def_rst_tx", tx2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
